packet_merge_arbiter: RTL and testbench
=======================================

Name: packet_merge_arbiter

Overview:
- Receive-side counterpart of the FSM router's per-port output interface.
- Presents port_ready to up to NUM_PORTS router output channels and accepts their port_valid/packet_data.
- Arbitrates round-robin and merges the accepted packets into one downstream valid/ready stream, tagged with the source port index.
- Sits between router egress ports and a single consumer (sink, buffer or next hop).

Parameters:
- DATA_WIDTH, 32, packet width per port and on output.
- NUM_PORTS, 4, number of input channels (2..16).
- SRC_WIDTH, 2, width of source tag; must be >= clog2(NUM_PORTS).
- RELEASE_TIMEOUT, 16, cycles to wait in RELEASE for the upstream to drop valid before forcing recovery (1..255).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- port_data_in  input  NUM_PORTS*DATA_WIDTH  flattened per-port packet data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- port_valid_in  input  NUM_PORTS  per-port packet valid, driven by the router.
- port_ready_out  output  NUM_PORTS  per-port ready; a 1->0 transition on the granted port is the acknowledge.
- out_data  output  DATA_WIDTH  merged packet.
- out_src  output  SRC_WIDTH  index of the port the packet came from.
- out_valid  output  1  downstream valid.
- out_ready  input  1  downstream ready.
- busy  output  1  high in any state other than IDLE.
- merge_state  output  2  current FSM state.
- pkt_count  output  16  accepted-packet counter; wraps modulo 2^16.
- err_timeout  output  1  sticky; set on release timeout, cleared only by rst.

Behaviour:
- Reset values:
  - port_ready_out = all ones.
  - out_data = 0, out_src = 0, out_valid = 0, busy = 0, merge_state = IDLE.
  - pkt_count = 0, err_timeout = 0.
  - Internal last_grant = NUM_PORTS-1, so port 0 has first priority.
  - Release counter = 0.
- States: IDLE=2'b00, SEND=2'b01, RELEASE=2'b10, RECOVER=2'b11.
- IDLE:
  - Requests are port_valid_in & port_ready_out.
  - If any request is present, grant the first requesting port scanning from (last_grant+1) mod NUM_PORTS upward with wrap.
  - On the grant edge:
    - out_data <= that port's data; out_src <= index; out_valid <= 1.
    - port_ready_out[g] <= 0; pkt_count += 1; busy <= 1.
    - Next state is SEND.
  - Latency: valid sampled at edge N gives out_valid high after edge N.
  - No request: remain in IDLE.
- SEND:
  - Hold out_data, out_src and out_valid stable until out_valid & out_ready are both high on an edge.
  - On that edge: out_valid <= 0, release counter <= 0, next state RELEASE.
  - No cap on stall length.
- RELEASE:
  - If port_valid_in[g] == 0: port_ready_out[g] <= 1, last_grant <= g, next state IDLE.
  - Otherwise increment the release counter.
  - When the counter reaches RELEASE_TIMEOUT-1 with valid still high: err_timeout <= 1, next state RECOVER.
- RECOVER:
  - One cycle: port_ready_out[g] <= 1, last_grant <= g, next state IDLE.
- Non-granted ports:
  - Their port_ready_out stays high throughout.
  - Their valid is held by the upstream and served later; no data is ever taken from them outside IDLE.
- A port with valid still high when its ready returns high is treated as a new packet. The upstream router drops valid before re-presenting.
- Simultaneous requests from all ports: strictly one grant per IDLE visit.
- Rotation guarantee: every requesting port is served within NUM_PORTS grants.
- rst asserted mid-operation:
  - Immediately returns all outputs and state to reset values.
  - Any in-flight packet is discarded and not re-counted.

Optional Feature:
- Macro: PKT_MERGE_PARITY_EN.
- Defined:
  - Extra output out_parity (1 bit) = XOR-reduction of out_data.
  - Registered on the grant edge together with out_data.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single packet: reset; port 2 valid with data 0xDEADBEEF, out_ready=1.
  - Next cycle: out_valid=1, out_data=0xDEADBEEF, out_src=2, port_ready_out=4'b1011, pkt_count=1.
  - Drop valid[2]: ready[2] returns 1 and state returns to IDLE.
- Round-robin: all four ports valid continuously, releasing promptly.
  - Grant order is 0,1,2,3,0.
  - out_src sequence matches; pkt_count=5.
- Backpressure: out_ready=0 for 10 cycles after a grant.
  - out_valid stays 1 with out_data stable; state=SEND, busy=1.
  - Raising out_ready gives exactly one transfer.
- Release timeout: RELEASE_TIMEOUT=4; granted port keeps valid high.
  - err_timeout=1 after RELEASE plus 4 cycles, then RECOVER.
  - ready[g] returns to 1 and the FSM returns to IDLE.
  - err_timeout stays 1 until rst.
- Mid-packet reset: assert rst while in SEND.
  - out_valid=0, port_ready_out=4'b1111, pkt_count=0, merge_state=00 before the next edge.
- Parity (macro defined): data 0x00000007 gives out_parity=1; data 0x00000003 gives out_parity=0.

Source files
------------

// File: rtl/packet_merge_arbiter.sv
// Round-robin merge of NUM_PORTS router egress channels into one valid/ready stream tagged with the source port.
// Optional out_parity output (XOR of out_data) is present when PKT_MERGE_PARITY_EN is defined.
module packet_merge_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_PORTS       = 4,
  parameter int SRC_WIDTH       = 2,
  parameter int RELEASE_TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data_in,
  input  logic [NUM_PORTS-1:0]            port_valid_in,
  output logic [NUM_PORTS-1:0]            port_ready_out,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [SRC_WIDTH-1:0]            out_src,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic [1:0]                      merge_state,
  output logic [15:0]                     pkt_count,
`ifdef PKT_MERGE_PARITY_EN
  output logic                            out_parity,
`endif
  output logic                            err_timeout
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SEND    = 2'b01,
    RELEASE = 2'b10,
    RECOVER = 2'b11
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          last_grant_q, last_grant_d;
  logic [IDX_W-1:0]          cur_g_q, cur_g_d;
  logic [7:0]                rel_cnt_q, rel_cnt_d;
  logic [NUM_PORTS-1:0]      ready_q, ready_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [SRC_WIDTH-1:0]      src_q, src_d;
  logic                      valid_q, valid_d;
  logic [15:0]               count_q, count_d;
  logic                      err_q, err_d;
`ifdef PKT_MERGE_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic [DATA_WIDTH-1:0]     port_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]      req;
  logic                      req_any;
  logic [IDX_W-1:0]          pick;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign port_data[i] = port_data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan downward from the farthest candidate so the nearest one after last_grant wins.
  always_comb begin
    req     = port_valid_in & ready_q;
    req_any = 1'b0;
    pick    = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req[(int'(last_grant_q) + 1 + k) % NUM_PORTS]) begin
        req_any = 1'b1;
        pick    = IDX_W'((int'(last_grant_q) + 1 + k) % NUM_PORTS);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_g_d      = cur_g_q;
    rel_cnt_d    = rel_cnt_q;
    ready_d      = ready_q;
    data_d       = data_q;
    src_d        = src_q;
    valid_d      = valid_q;
    count_d      = count_q;
    err_d        = err_q;
`ifdef PKT_MERGE_PARITY_EN
    parity_d     = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          cur_g_d       = pick;
          data_d        = port_data[pick];
          src_d         = SRC_WIDTH'(pick);
          valid_d       = 1'b1;
          ready_d[pick] = 1'b0;
          count_d       = count_q + 16'd1;
`ifdef PKT_MERGE_PARITY_EN
          parity_d      = ^port_data[pick];
`endif
          state_d       = SEND;
        end
      end
      SEND: begin
        if (valid_q && out_ready) begin
          valid_d   = 1'b0;
          rel_cnt_d = 8'd0;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (!port_valid_in[cur_g_q]) begin
          ready_d[cur_g_q] = 1'b1;
          last_grant_d     = cur_g_q;
          state_d          = IDLE;
        end else if (rel_cnt_q == 8'(RELEASE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RECOVER;
        end else begin
          rel_cnt_d = rel_cnt_q + 8'd1;
        end
      end
      RECOVER: begin
        ready_d[cur_g_q] = 1'b1;
        last_grant_d     = cur_g_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      cur_g_q      <= '0;
      rel_cnt_q    <= 8'd0;
      ready_q      <= '1;
      data_q       <= '0;
      src_q        <= '0;
      valid_q      <= 1'b0;
      count_q      <= 16'd0;
      err_q        <= 1'b0;
`ifdef PKT_MERGE_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_g_q      <= cur_g_d;
      rel_cnt_q    <= rel_cnt_d;
      ready_q      <= ready_d;
      data_q       <= data_d;
      src_q        <= src_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      err_q        <= err_d;
`ifdef PKT_MERGE_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign port_ready_out = ready_q;
  assign out_data       = data_q;
  assign out_src        = src_q;
  assign out_valid      = valid_q;
  assign busy           = (state_q != IDLE);
  assign merge_state    = state_q;
  assign pkt_count      = count_q;
  assign err_timeout    = err_q;
`ifdef PKT_MERGE_PARITY_EN
  assign out_parity     = parity_q;
`endif

endmodule

// File: tb/tb_packet_merge_arbiter.sv
// Directed self-checking bench for packet_merge_arbiter (4 ports, RELEASE_TIMEOUT=4).
// Parity checks are included when PKT_MERGE_PARITY_EN is defined.
module tb_packet_merge_arbiter;

  localparam int DW = 32;
  localparam int NP = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*DW-1:0] port_data_in;
  logic [NP-1:0]    port_valid_in;
  logic [NP-1:0]    port_ready_out;
  logic [DW-1:0]    out_data;
  logic [1:0]       out_src;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [1:0]       merge_state;
  logic [15:0]      pkt_count;
  logic             err_timeout;
`ifdef PKT_MERGE_PARITY_EN
  logic             out_parity;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  packet_merge_arbiter #(
    .DATA_WIDTH(DW), .NUM_PORTS(NP), .SRC_WIDTH(2), .RELEASE_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .port_data_in(port_data_in), .port_valid_in(port_valid_in),
    .port_ready_out(port_ready_out),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .merge_state(merge_state),
    .pkt_count(pkt_count),
`ifdef PKT_MERGE_PARITY_EN
    .out_parity(out_parity),
`endif
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_data(input int p, input logic [31:0] d);
    port_data_in[p*DW +: DW] = d;
  endtask

  initial begin
    rst           = 1'b1;
    port_data_in  = '0;
    port_valid_in = '0;
    out_ready     = 1'b0;

    // Reset state
    tick();
    check("rst_ready", 32'(port_ready_out), 32'hF);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_src", 32'(out_src), 32'h0);
    check("rst_state", 32'(merge_state), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_count", 32'(pkt_count), 32'h0);
    check("rst_err", 32'(err_timeout), 32'h0);
    rst = 1'b0;

    // Single packet from port 2
    set_data(2, 32'hDEADBEEF);
    port_valid_in = 4'b0100;
    out_ready     = 1'b1;
    tick();
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_data", out_data, 32'hDEADBEEF);
    check("single_src", 32'(out_src), 32'h2);
    check("single_ready", 32'(port_ready_out), 32'hB);
    check("single_count", 32'(pkt_count), 32'h1);
    check("single_state_send", 32'(merge_state), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    tick();
    check("single_xfer_valid", 32'(out_valid), 32'h0);
    check("single_state_rel", 32'(merge_state), 32'h2);
    port_valid_in = 4'b0000;
    tick();
    check("single_ready_back", 32'(port_ready_out), 32'hF);
    check("single_state_idle", 32'(merge_state), 32'h0);
    check("single_busy_low", 32'(busy), 32'h0);

    // Round-robin with all ports requesting: 0,1,2,3,0
    do_reset();
    for (int p = 0; p < NP; p++) set_data(p, 32'h100 + 32'(p));
    port_valid_in = 4'b1111;
    out_ready     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_src", 32'(out_src), 32'(i % NP));
      check("rr_data", out_data, 32'h100 + 32'(i % NP));
      tick();
      port_valid_in[i % NP] = 1'b0;
      tick();
      check("rr_idle", 32'(merge_state), 32'h0);
      port_valid_in[i % NP] = 1'b1;
    end
    port_valid_in = 4'b0000;
    check("rr_count", 32'(pkt_count), 32'h5);

    // Backpressure: port 1 granted (last grant was 0), stalled 10 cycles
    set_data(1, 32'hCAFEF00D);
    out_ready     = 1'b0;
    port_valid_in = 4'b0010;
    tick();
    port_valid_in = 4'b0000;
    check("bp_src", 32'(out_src), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_data", out_data, 32'hCAFEF00D);
      check("bp_state", 32'(merge_state), 32'h1);
      check("bp_busy", 32'(busy), 32'h1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_xfer_valid", 32'(out_valid), 32'h0);
    check("bp_state_rel", 32'(merge_state), 32'h2);
    tick();
    check("bp_idle", 32'(merge_state), 32'h0);
    check("bp_one_xfer", 32'(out_valid), 32'h0);
    check("bp_count", 32'(pkt_count), 32'h6);

    // Release timeout: port 3 keeps valid high after transfer
    set_data(3, 32'h33);
    port_valid_in = 4'b1000;
    tick();
    check("to_src", 32'(out_src), 32'h3);
    tick();
    check("to_state_rel", 32'(merge_state), 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_still_rel", 32'(merge_state), 32'h2);
      check("to_err_low", 32'(err_timeout), 32'h0);
      check("to_ready_low", 32'(port_ready_out), 32'h7);
    end
    tick();
    check("to_err_set", 32'(err_timeout), 32'h1);
    check("to_recover", 32'(merge_state), 32'h3);
    port_valid_in = 4'b0000;
    tick();
    check("to_idle", 32'(merge_state), 32'h0);
    check("to_ready_back", 32'(port_ready_out), 32'hF);
    tick();
    check("to_err_sticky", 32'(err_timeout), 32'h1);
    check("to_count", 32'(pkt_count), 32'h7);

    // Mid-packet asynchronous reset while in SEND
    set_data(0, 32'h12345678);
    out_ready     = 1'b0;
    port_valid_in = 4'b0001;
    tick();
    check("mr_state_send", 32'(merge_state), 32'h1);
    rst = 1'b1;
    #1;
    check("mr_valid", 32'(out_valid), 32'h0);
    check("mr_ready", 32'(port_ready_out), 32'hF);
    check("mr_count", 32'(pkt_count), 32'h0);
    check("mr_state", 32'(merge_state), 32'h0);
    check("mr_err", 32'(err_timeout), 32'h0);
    port_valid_in = 4'b0000;
    tick();
    rst = 1'b0;

`ifdef PKT_MERGE_PARITY_EN
    // Parity follows XOR-reduction of the granted data
    out_ready = 1'b1;
    set_data(0, 32'h00000007);
    port_valid_in = 4'b0001;
    tick();
    check("par_odd", 32'(out_parity), 32'h1);
    port_valid_in = 4'b0000;
    do_reset();
    set_data(0, 32'h00000003);
    port_valid_in = 4'b0001;
    tick();
    check("par_even", 32'(out_parity), 32'h0);
    port_valid_in = 4'b0000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
